// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Shares one combinational radix-4 Booth multiplier (8x8 signed, 16-bit
//   product) among NREQ requesters. Requests are granted in round-robin order,
//   and each side uses a valid/ready handshake. The operands are registered
//   before the multiplier and the product is registered after it, so the
//   multiplier's combinational path never reaches a port.
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous, active-high reset
//   req_valid     [NREQ]    per-requester request valid
//   req_ready     [NREQ]    one-hot accept (all zero outside IDLE or in reset)
//   req_a/req_b   [8*NREQ]  flattened operands, requester i at [8i+7:8i]
//   resp_valid    response valid, held until resp_ready
//   resp_ready    response consumer ready
//   resp_id       [ID_W]    requester that owns the response
//   resp_product  [16]      signed product
//   busy          high whenever the FSM is not in IDLE
//
// Optional feature (macro BOOTH_ARB_ZERO_BYPASS_EN)
//   When the macro is defined, a request with a zero operand skips the MUL
//   state and responds with a product of 0 after 1 cycle. The operand
//   registers are left untouched. The results are the same either way; only
//   the latency changes.

// Combinational radix-4 Booth multiplier, signed 8x8 -> 16.
module boothmul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // Multiplier with the implicit b[-1] = 0 appended below the LSB.
  logic [8:0]  bx;
  logic [15:0] a16;
  logic [15:0] pp [4];

  assign bx  = {b, 1'b0};
  assign a16 = {{8{a[7]}}, a};

  // One Booth digit in {-2,-1,0,+1,+2} per overlapping bit triplet.
  function automatic logic [15:0] booth_pp(input logic [15:0] m, input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return m;
      3'b011:         return m << 1;
      3'b100:         return -(m << 1);
      3'b101, 3'b110: return -m;
      default:        return 16'h0000;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_pp
    assign pp[gi] = booth_pp(a16, bx[2*gi+2 -: 3]) << (2*gi);
  end

  assign p = pp[0] + pp[1] + pp[2] + pp[3];

endmodule

module booth_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ID_W-1:0]   resp_id,
  output logic [15:0]       resp_product,
  output logic              busy
);

  if (ID_W != $clog2(NREQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NREQ)");
  end

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t          state_reg;
  logic [7:0]      op_a_reg;
  logic [7:0]      op_b_reg;
  logic [ID_W-1:0] id_reg;
  logic [ID_W-1:0] last_grant_reg;
  logic            resp_valid_reg;
  logic [ID_W-1:0] resp_id_reg;
  logic [15:0]     resp_product_reg;

  logic [ID_W-1:0] winner;
  logic            win_found;
  logic            grant_en;
  logic [7:0]      win_a;
  logic [7:0]      win_b;
  logic [15:0]     product;
  logic [7:0]      a_lane [NREQ];
  logic [7:0]      b_lane [NREQ];

  // Unpack the flattened operand buses into per-requester lanes.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign a_lane[gi] = req_a[8*gi +: 8];
    assign b_lane[gi] = req_b[8*gi +: 8];
  end

  // Round-robin search: start just after the last grant and wrap around.
  // This works for any NREQ, including values that are not powers of two.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        winner    = idx[ID_W-1:0];
      end
    end
  end

  assign win_a    = a_lane[winner];
  assign win_b    = b_lane[winner];
  assign grant_en = (state_reg == IDLE) && !rst && win_found;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_en && (winner == ID_W'(gi));
  end

  boothmul u_mul (
    .a (op_a_reg),
    .b (op_b_reg),
    .p (product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      op_a_reg         <= '0;
      op_b_reg         <= '0;
      id_reg           <= '0;
      last_grant_reg   <= ID_W'(NREQ - 1);
      resp_valid_reg   <= 1'b0;
      resp_id_reg      <= '0;
      resp_product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            last_grant_reg <= winner;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
            if (win_a == 8'h00 || win_b == 8'h00) begin
              // A zero operand has a known product, so the multiplier is skipped.
              resp_product_reg <= 16'h0000;
              resp_id_reg      <= winner;
              resp_valid_reg   <= 1'b1;
              state_reg        <= RESP;
            end else begin
              op_a_reg  <= win_a;
              op_b_reg  <= win_b;
              id_reg    <= winner;
              state_reg <= MUL;
            end
`else
            op_a_reg  <= win_a;
            op_b_reg  <= win_b;
            id_reg    <= winner;
            state_reg <= MUL;
`endif
          end
        end
        MUL: begin
          resp_product_reg <= product;
          resp_id_reg      <= id_reg;
          resp_valid_reg   <= 1'b1;
          state_reg        <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign resp_valid   = resp_valid_reg;
  assign resp_id      = resp_id_reg;
  assign resp_product = resp_product_reg;
  assign busy         = (state_reg != IDLE);

endmodule
